nd_1ton: RTL

//  Generalised 1-to-N message-routing node; successor of the fixed 1-to-2 compare node.

---
 rtl/nd_1ton_pkg.sv | 21 ++
 rtl/nd_1ton_fifo.sv | 49 ++++
 rtl/nd_1ton.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/nd_1ton_pkg.sv
// Shared types and default field widths for the nd_1ton 1-to-N routing node.
// FSM encodings here are also used by the sink-side I/O models.
package nd_1ton_pkg;

   localparam int NS_ADDRESS_SIZE = 8;
   localparam int NS_DATA_SIZE    = 8;
   localparam int NS_REDUN_SIZE   = 8;
   localparam int ND_MAX_OUT      = 8;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_ACK  = 1'b1
   } rx_state_t;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_REQ  = 2'd1,
      T_WAIT = 2'd2
   } tx_state_t;

endpackage

// File: rtl/nd_1ton_fifo.sv
// nd_fifo: per-output message buffer, 2**LOG2 deep, wrap-bit pointers, async active-low reset.
// Full is derived from the registered pointers, so a same-cycle pop never frees a slot for a push.
module nd_fifo
   import nd_1ton_pkg::*;
#(
   parameter int W    = 24,
   parameter int LOG2 = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int DEPTH = 2 ** LOG2;

   logic [W-1:0]  mem [DEPTH];
   logic [LOG2:0] wr_ptr;
   logic [LOG2:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (wr_ptr[LOG2] != rd_ptr[LOG2]) &&
                    (wr_ptr[LOG2-1:0] == rd_ptr[LOG2-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[LOG2-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; emptiness is defined by the pointers alone.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[LOG2-1:0]] <= din;
   end

endmodule

// File: rtl/nd_1ton.sv
// nd_1ton: 1-to-N message router with 4-phase input, per-output FIFO and 4-phase TX FSMs.
// Optional redundancy check and drop counter enabled by defining NS_ND_RED_CHECK_EN.
module nd_1ton
   import nd_1ton_pkg::*;
#(
   parameter int ASZ       = NS_ADDRESS_SIZE,
   parameter int DSZ       = NS_DATA_SIZE,
   parameter int RSZ       = NS_REDUN_SIZE,
   parameter int NUM_OUT   = 4,
   parameter int FIFO_LOG2 = 2,
   parameter logic [(NUM_OUT-1)*ASZ-1:0] REF_VALS = {8'd48, 8'd32, 8'd16}
) (
   input  logic                   i_clk,
   input  logic                   reset,
   output logic                   ready,
   input  logic [ASZ-1:0]         rcv0_addr,
   input  logic [DSZ-1:0]         rcv0_dat,
   input  logic [RSZ-1:0]         rcv0_red,
   input  logic                   rcv0_req,
   output logic                   rcv0_ack,
   output logic [NUM_OUT*ASZ-1:0] snd_addr,
   output logic [NUM_OUT*DSZ-1:0] snd_dat,
   output logic [NUM_OUT*RSZ-1:0] snd_red,
   output logic [NUM_OUT-1:0]     snd_req,
   input  logic [NUM_OUT-1:0]     snd_ack,
   output logic [7:0]             err_cnt
);

   localparam int MW = ASZ + DSZ + RSZ;
   localparam int KW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam int SW = ((ASZ > DSZ) ? ASZ : DSZ) + RSZ + 1;

   function automatic logic [RSZ-1:0] red_calc(input logic [ASZ-1:0] a,
                                                input logic [DSZ-1:0] d);
      logic [SW-1:0] s;
      s = SW'(a) + SW'(d);
      return s[RSZ-1:0];
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   rx_state_t            rx_state;
   rx_state_t            rx_next;
   logic [KW-1:0]        route_k;
   logic [MW-1:0]        msg_p0;
   logic                 red_ok;
   logic [NUM_OUT-1:0]   fifo_push;
   logic [NUM_OUT-1:0]   fifo_full;

   assign msg_p0 = {rcv0_addr, rcv0_dat, rcv0_red};

   // Unsigned range partition: count thresholds strictly below the address.
   always_comb begin
      route_k = '0;
      for (int j = 0; j < NUM_OUT - 1; j++) begin
         if (rcv0_addr > REF_VALS[j*ASZ +: ASZ]) route_k = route_k + 1'b1;
      end
   end

`ifdef NS_ND_RED_CHECK_EN
   logic drop;
   assign red_ok = (rcv0_red == red_calc(rcv0_addr, rcv0_dat));
   assign drop   = (rx_state == R_IDLE) && ready && rcv0_req && !red_ok;

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset)    err_cnt <= 8'd0;
      else if (drop) err_cnt <= sat_inc8(err_cnt);
   end
`else
   assign red_ok  = 1'b1;
   assign err_cnt = 8'd0;
`endif

   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) begin
         ready    <= 1'b0;
         rx_state <= R_IDLE;
      end else begin
         ready    <= 1'b1;
         rx_state <= rx_next;
      end
   end

   // A corrupted message is acknowledged without being buffered, so it never waits on a full FIFO.
   always_comb begin
      rx_next   = rx_state;
      fifo_push = '0;
      case (rx_state)
         R_IDLE: begin
            if (ready && rcv0_req) begin
               if (!red_ok) begin
                  rx_next = R_ACK;
               end else if (!fifo_full[route_k]) begin
                  fifo_push[route_k] = 1'b1;
                  rx_next            = R_ACK;
               end
            end
         end
         R_ACK:   if (!rcv0_req) rx_next = R_IDLE;
         default: rx_next = R_IDLE;
      endcase
   end

   assign rcv0_ack = (rx_state == R_ACK);

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
      tx_state_t     tx_state;
      tx_state_t     tx_next;
      logic [MW-1:0] head;
      logic [MW-1:0] snd_msg_p1;
      logic          pop;
      logic          full;
      logic          empty;
      logic          load;

      nd_fifo #(
         .W    (MW),
         .LOG2 (FIFO_LOG2)
      ) u_fifo (
         .clk   (i_clk),
         .rst_n (reset),
         .push  (fifo_push[k]),
         .din   (msg_p0),
         .pop   (pop),
         .dout  (head),
         .full  (full),
         .empty (empty)
      );

      assign fifo_full[k] = full;
      assign load         = (tx_state == T_IDLE) && !empty;

      always_comb begin
         tx_next = tx_state;
         pop     = 1'b0;
         case (tx_state)
            T_IDLE: if (!empty) tx_next = T_REQ;
            T_REQ: begin
               if (snd_ack[k]) begin
                  pop     = 1'b1;
                  tx_next = T_WAIT;
               end
            end
            T_WAIT:  if (!snd_ack[k]) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
         endcase
      end

      // --- output stage: head latched while req is up, so fields stay stable until ack ---
      always_ff @(posedge i_clk or negedge reset) begin
         if (!reset) begin
            tx_state   <= T_IDLE;
            snd_msg_p1 <= '0;
         end else begin
            tx_state <= tx_next;
            if (load) snd_msg_p1 <= head;
         end
      end

      assign snd_req[k]            = (tx_state == T_REQ);
      assign snd_addr[k*ASZ +: ASZ] = snd_msg_p1[MW-1 -: ASZ];
      assign snd_dat[k*DSZ +: DSZ]  = snd_msg_p1[RSZ +: DSZ];
      assign snd_red[k*RSZ +: RSZ]  = snd_msg_p1[RSZ-1:0];
   end

endmodule
